// File: rtl/gyro_cal_ctrl.sv
// Gyro bias calibration and correction: averages 2^BIAS_LOG2 samples per axis, then emits raw - bias, saturated.
// Define GYRO_CAL_WDOG_EN to build the sample-timeout watchdog and the FAULT state.
module gyro_cal_ctrl #(
  parameter int BIAS_LOG2   = 6,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sample_valid,
  input  logic signed [15:0] pitch_raw,
  input  logic signed [15:0] roll_raw,
  input  logic signed [15:0] yaw_raw,
  output logic signed [15:0] pitch_gyro_o,
  output logic signed [15:0] roll_gyro_o,
  output logic signed [15:0] yaw_gyro_o,
  output logic               integ_oe,
  output logic               bias_done,
  output logic               busy,
  output logic               fault
);

  localparam int AW = 16 + BIAS_LOG2;
  localparam logic [BIAS_LOG2-1:0] CNT_ONE = BIAS_LOG2'(1);

  typedef enum logic [1:0] {S_IDLE, S_BIAS, S_RUN, S_FAULT} state_t;

  state_t state_q, state_d;

  logic signed [15:0]   raw    [3];
  logic signed [AW-1:0] acc_q  [3];
  logic signed [AW-1:0] sum_d  [3];
  logic signed [AW-1:0] shr_d  [3];
  logic signed [15:0]   bias_q [3];
  logic signed [16:0]   diff_d [3];
  logic signed [15:0]   corr_d [3];
  logic signed [15:0]   out_q  [3];
  logic [BIAS_LOG2-1:0] cnt_q;
  logic                 integ_q;
  logic                 last_sample;
  logic                 wd_expire;

  assign raw[0] = pitch_raw;
  assign raw[1] = roll_raw;
  assign raw[2] = yaw_raw;

  assign last_sample = sample_valid && (cnt_q == '1);

`ifdef GYRO_CAL_WDOG_EN
  localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYC - 1);
  logic [23:0] wd_q;

  // Expires on the TIMEOUT_CYC-th consecutive sample-free cycle.
  assign wd_expire = !sample_valid && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst || start || sample_valid || !(state_q == S_BIAS || state_q == S_RUN)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 24'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign wd_expire      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_BIAS;
    end else begin
      case (state_q)
        S_BIAS: begin
          if (last_sample)    state_d = S_RUN;
          else if (wd_expire) state_d = S_FAULT;
        end
        S_RUN: begin
          if (wd_expire) state_d = S_FAULT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == S_BIAS);
    bias_done = (state_q == S_RUN);
`ifdef GYRO_CAL_WDOG_EN
    fault     = (state_q == S_FAULT);
`else
    fault     = 1'b0;
`endif
  end

  // Accumulator is wide enough that the full 2^BIAS_LOG2-sample sum never overflows.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum_d[i]  = acc_q[i] + AW'(raw[i]);
      shr_d[i]  = sum_d[i] >>> BIAS_LOG2;
      diff_d[i] = 17'(raw[i]) - 17'(bias_q[i]);
      if (diff_d[i][16] != diff_d[i][15]) begin
        corr_d[i] = diff_d[i][16] ? 16'sh8000 : 16'sh7FFF;
      end else begin
        corr_d[i] = diff_d[i][15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= '0;
        bias_q[i] <= '0;
        out_q[i]  <= '0;
      end
      cnt_q   <= '0;
      integ_q <= 1'b0;
    end else begin
      integ_q <= 1'b0;
      if (state_q == S_BIAS && sample_valid) begin
        for (int i = 0; i < 3; i++) begin
          acc_q[i] <= sum_d[i];
          if (last_sample) bias_q[i] <= shr_d[i][15:0];
        end
        cnt_q <= cnt_q + CNT_ONE;
      end else if (state_q == S_RUN && sample_valid) begin
        for (int i = 0; i < 3; i++) begin
          out_q[i] <= corr_d[i];
        end
        integ_q <= 1'b1;
      end
    end
  end

  assign pitch_gyro_o = out_q[0];
  assign roll_gyro_o  = out_q[1];
  assign yaw_gyro_o   = out_q[2];
  assign integ_oe     = integ_q;

endmodule

// File: tb/tb_gyro_cal_ctrl.sv
// Bench for gyro_cal_ctrl (BIAS_LOG2=2, TIMEOUT_CYC=16): directed scenarios then random traffic vs. a sample-list model.
module tb_gyro_cal_ctrl;
  localparam int BL = 2;
  localparam int TO = 16;
  localparam int NS = 4;
`ifdef GYRO_CAL_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int M_IDLE = 0, M_CAL = 1, M_RUN = 2, M_FLT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sample_valid;
  logic signed [15:0] pitch_raw, roll_raw, yaw_raw;
  logic signed [15:0] pitch_gyro_o, roll_gyro_o, yaw_gyro_o;
  logic integ_oe, bias_done, busy, fault;

  gyro_cal_ctrl #(.BIAS_LOG2(BL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .pitch_raw(pitch_raw), .roll_raw(roll_raw), .yaw_raw(yaw_raw),
    .pitch_gyro_o(pitch_gyro_o), .roll_gyro_o(roll_gyro_o), .yaw_gyro_o(yaw_gyro_o),
    .integ_oe(integ_oe), .bias_done(bias_done), .busy(busy), .fault(fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a list of calibration samples plus the rules, no cycle-level mechanics.
  int m_mode, idle_run;
  int qp[$], qr[$], qy[$];
  int bp, br, by, ep, er, ey, eoe;

  task automatic chk(input string tag, input integer obs, input integer exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_avg(input int s);
    int q;
    q = s / NS;
    if ((s % NS) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; idle_run = 0;
    qp.delete(); qr.delete(); qy.delete();
    bp = 0; br = 0; by = 0; ep = 0; er = 0; ey = 0; eoe = 0;
  endtask

  task automatic model_step(input logic st, input logic sv, input int p, input int r, input int y);
    int sp, sr, sy;
    eoe = 0;
    if (st) begin
      model_reset();
      m_mode = M_CAL;
    end else if (m_mode == M_CAL) begin
      if (sv) begin
        qp.push_back(p); qr.push_back(r); qy.push_back(y);
        idle_run = 0;
        if (qp.size() == NS) begin
          sp = 0; sr = 0; sy = 0;
          foreach (qp[k]) begin sp += qp[k]; sr += qr[k]; sy += qy[k]; end
          bp = floor_avg(sp); br = floor_avg(sr); by = floor_avg(sy);
          m_mode = M_RUN;
        end
      end else begin
        idle_run++;
        if (WD && idle_run >= TO) m_mode = M_FLT;
      end
    end else if (m_mode == M_RUN) begin
      if (sv) begin
        ep = sat16(p - bp); er = sat16(r - br); ey = sat16(y - by);
        eoe = 1; idle_run = 0;
      end else begin
        idle_run++;
        if (WD && idle_run >= TO) m_mode = M_FLT;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pitch"}, pitch_gyro_o, ep);
    chk({tag, ".roll"},  roll_gyro_o,  er);
    chk({tag, ".yaw"},   yaw_gyro_o,   ey);
    chk({tag, ".oe"},    integ_oe,     eoe);
    chk({tag, ".done"},  bias_done,    (m_mode == M_RUN) ? 1 : 0);
    chk({tag, ".busy"},  busy,         (m_mode == M_CAL) ? 1 : 0);
    chk({tag, ".fault"}, fault,        (m_mode == M_FLT) ? 1 : 0);
  endtask

  task automatic cyc(input string tag, input logic st, input logic sv, input int p, input int r, input int y);
    start = st; sample_valid = sv;
    pitch_raw = 16'(p); roll_raw = 16'(r); yaw_raw = 16'(y);
    @(posedge clk); #1;
    model_step(st, sv, p, r, y);
    start = 1'b0; sample_valid = 1'b0;
    check_all(tag);
  endtask

  task automatic samp(input string tag, input int p, input int r, input int y);
    cyc(tag, 1'b0, 1'b1, p, r, y);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) cyc(tag, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
    pitch_raw = '0; roll_raw = '0; yaw_raw = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pitch", pitch_gyro_o, 0);
    chk("rst.oe", integ_oe, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", bias_done, 0);
    chk("rst.fault", fault, 0);
    rst = 1'b0;

    samp("idle_ign", 5, 5, 5);
    chk("idle_ign.oe", integ_oe, 0);

    // Basic calibration: pitch bias = floor(46/4) = 11.
    cyc("cal1.start", 1'b1, 1'b0, 0, 0, 0);
    chk("cal1.busy", busy, 1);
    samp("cal1.s0", 10, 0, 0);
    samp("cal1.s1", 11, 0, 0);
    samp("cal1.s2", 12, 0, 0);
    chk("cal1.done_early", bias_done, 0);
    samp("cal1.s3", 13, 0, 0);
    chk("cal1.done", bias_done, 1);
    samp("run1", 111, 0, 0);
    chk("run1.pitch100", pitch_gyro_o, 100);
    chk("run1.oe", integ_oe, 1);
    idle("run1.hold", 1);
    chk("run1.oe_off", integ_oe, 0);
    chk("run1.hold100", pitch_gyro_o, 100);

    // Negative floor (-11/4 -> -3) and positive saturation.
    cyc("cal2.start", 1'b1, 1'b0, 0, 0, 0);
    samp("cal2.s0", 0, -3, 0);
    samp("cal2.s1", 0, -3, 0);
    samp("cal2.s2", 0, -3, 0);
    samp("cal2.s3", 0, -2, 0);
    samp("cal2.floor", 0, 0, 0);
    chk("cal2.roll3", roll_gyro_o, 3);
    samp("cal2.sat", 0, 32767, 0);
    chk("cal2.roll_sat", roll_gyro_o, 32767);

    // Negative saturation.
    cyc("cal3.start", 1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 4; k++) samp("cal3.s", 0, 0, 100);
    samp("cal3.sat", 0, 0, -32768);
    chk("cal3.yaw_sat", yaw_gyro_o, -32768);

    // Start beats a coincident sample; that sample is not accumulated.
    cyc("prio", 1'b1, 1'b1, 50, 50, 50);
    chk("prio.oe", integ_oe, 0);
    chk("prio.busy", busy, 1);
    chk("prio.yaw0", yaw_gyro_o, 0);
    samp("prio.s0", 1, 2, 3);
    samp("prio.s1", 1, 2, 3);
    samp("prio.s2", 1, 2, 3);
    chk("prio.busy3", busy, 1);
    samp("prio.s3", 1, 2, 3);
    chk("prio.done4", bias_done, 1);

`ifdef GYRO_CAL_WDOG_EN
    samp("wd.last", 7, 7, 7);
    idle("wd.quiet", TO - 1);
    chk("wd.fault_early", fault, 0);
    idle("wd.expire", 1);
    chk("wd.fault", fault, 1);
    samp("wd.ignored", 9, 9, 9);
    chk("wd.oe", integ_oe, 0);
    cyc("wd.restart", 1'b1, 1'b0, 0, 0, 0);
    chk("wd.busy", busy, 1);
    chk("wd.fault_clr", fault, 0);
`else
    idle("nowd.quiet", 100);
    chk("nowd.fault", fault, 0);
    chk("nowd.done", bias_done, 1);
    cyc("nowd.restart", 1'b1, 1'b0, 0, 0, 0);
`endif

    // Reset mid-calibration discards everything.
    cyc("rmid.start", 1'b1, 1'b0, 0, 0, 0);
    samp("rmid.s0", 20, 20, 20);
    samp("rmid.s1", 20, 20, 20);
    do_reset("rmid.rst");
    chk("rmid.busy", busy, 0);
    for (int k = 0; k < 5; k++) samp("rmid.ign", 30, 30, 30);
    chk("rmid.oe", integ_oe, 0);
    chk("rmid.done", bias_done, 0);

    // Random traffic against the model.
    for (int rnd = 0; rnd < 6; rnd++) begin
      cyc("rnd.start", 1'b1, 1'b0, 0, 0, 0);
      for (int k = 0; k < 40; k++) begin
        int p, r, y;
        logic sv;
        sv = ($urandom_range(0, 2) != 0);
        if (rnd[0]) begin
          p = int'($urandom_range(0, 65535)) - 32768;
          r = int'($urandom_range(0, 65535)) - 32768;
          y = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          p = int'($urandom_range(0, 400)) - 200;
          r = int'($urandom_range(0, 400)) - 200;
          y = int'($urandom_range(0, 400)) - 200;
        end
        cyc("rnd", 1'b0, sv, p, r, y);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
